// File: rtl/grid_scan_sched_pkg.sv
// Shared definitions for the grid solvers: default geometry, direction
// encoding with its row/column steps, and the scan sequencer state type.
package grid_scan_sched_pkg;

  localparam int GRID_LEN    = 20;
  localparam int GRID_RUN    = 4;
  localparam int GRID_ADDR_W = 9;
  localparam int GRID_DATA_W = 8;
  localparam int GRID_RES_W  = 32;

  localparam logic [1:0] DIR_RIGHT   = 2'd0;
  localparam logic [1:0] DIR_DOWN    = 2'd1;
  localparam logic [1:0] DIR_DIAG_DR = 2'd2;
  localparam logic [1:0] DIR_DIAG_DL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_DRAIN,
    ST_CMP,
    ST_ADV,
    ST_FIN
  } scan_state_e;

  function automatic int dir_dr(input logic [1:0] dir);
    return (dir == DIR_RIGHT) ? 0 : 1;
  endfunction

  function automatic int dir_dc(input logic [1:0] dir);
    case (dir)
      DIR_RIGHT:   return 1;
      DIR_DOWN:    return 0;
      DIR_DIAG_DR: return 1;
      default:     return -1;
    endcase
  endfunction

  // Signed end-cell test; the down-left walk can leave through column -1.
  function automatic logic win_in_grid(input int row, input int col,
                                       input logic [1:0] dir,
                                       input int len, input int run);
    int er;
    int ec;
    er = row + (run - 1) * dir_dr(dir);
    ec = col + (run - 1) * dir_dc(dir);
    return (er >= 0) && (er < len) && (ec >= 0) && (ec < len);
  endfunction

endpackage

// File: rtl/grid_scan_sched_win_acc.sv
// Window product accumulator with per-window saturation, plus the
// strict-greater running maximum and the origin/direction that produced it.
module grid_win_acc #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_init,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_cmp,
  input  logic [4:0]        i_row,
  input  logic [4:0]        i_col,
  input  logic [1:0]        i_dir,
  output logic [RES_W-1:0]  o_result,
  output logic [4:0]        o_row,
  output logic [4:0]        o_col,
  output logic [1:0]        o_dir,
  output logic              o_ovf
);

  localparam int ACC_W = RES_W + DATA_W;

  logic [ACC_W-1:0] r_acc;
  logic             r_sat;
  logic [4:0]       r_org_row;
  logic [4:0]       r_org_col;
  logic [1:0]       r_org_dir;
  logic [RES_W-1:0] r_max;
  logic [4:0]       r_max_row;
  logic [4:0]       r_max_col;
  logic [1:0]       r_max_dir;
  logic [ACC_W-1:0] w_full;

  assign w_full = r_acc * ACC_W'(i_data);
  assign o_ovf  = i_vld && !r_sat && !i_init && (|w_full[ACC_W-1:RES_W]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_sat     <= 1'b0;
      r_org_row <= '0;
      r_org_col <= '0;
      r_org_dir <= '0;
      r_max     <= '0;
      r_max_row <= '0;
      r_max_col <= '0;
      r_max_dir <= '0;
    end else begin
      if (i_clr) begin
        r_max     <= '0;
        r_max_row <= '0;
        r_max_col <= '0;
        r_max_dir <= '0;
      end else if (i_cmp && (r_acc[RES_W-1:0] > r_max)) begin
        r_max     <= r_acc[RES_W-1:0];
        r_max_row <= r_org_row;
        r_max_col <= r_org_col;
        r_max_dir <= r_org_dir;
      end

      if (i_init) begin
        r_acc     <= ACC_W'(1);
        r_sat     <= 1'b0;
        r_org_row <= i_row;
        r_org_col <= i_col;
        r_org_dir <= i_dir;
      end else if (i_vld && !r_sat) begin
        // Once saturated the window stays all-ones, even if a zero byte follows.
        if (|w_full[ACC_W-1:RES_W]) begin
          r_acc <= {{DATA_W{1'b0}}, {RES_W{1'b1}}};
          r_sat <= 1'b1;
        end else begin
          r_acc <= w_full;
        end
      end
    end
  end

  assign o_result = r_max;
  assign o_row    = r_max_row;
  assign o_col    = r_max_col;
  assign o_dir    = r_max_dir;

endmodule

// File: rtl/grid_scan_sched.sv
// Serialized max-window-product scan over a LEN x LEN byte grid held in a
// single-port ROM with one-cycle read latency.
module grid_scan_sched
  import grid_scan_sched_pkg::*;
#(
  parameter int LEN    = GRID_LEN,
  parameter int RUN    = GRID_RUN,
  parameter int ADDR_W = GRID_ADDR_W,
  parameter int DATA_W = GRID_DATA_W,
  parameter int RES_W  = GRID_RES_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [RES_W-1:0]  result,
  output logic [4:0]        res_row,
  output logic [4:0]        res_col,
  output logic [1:0]        res_dir,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int K_W = (RUN > 1) ? $clog2(RUN) : 1;

  scan_state_e    r_state;
  scan_state_e    w_next;
  logic [4:0]     r_row;
  logic [4:0]     r_col;
  logic [1:0]     r_dir;
  logic [K_W-1:0] r_k;
  logic           r_last;
  logic           r_vld;
  logic           r_busy;
  logic           r_done;
  logic           r_err;

  logic           w_start_acc;
  logic           w_init;
  logic           w_cmp;
  logic           w_adv;
  logic           w_wrap;
  logic           w_in;
  logic           w_ovf;
  logic [4:0]     w_nrow;
  logic [4:0]     w_ncol;
  logic [1:0]     w_ndir;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_in        = win_in_grid(int'(r_row), int'(r_col), r_dir, LEN, RUN);

  always_comb begin
    w_ndir = r_dir + 2'd1;
    w_ncol = r_col;
    w_nrow = r_row;
    w_wrap = 1'b0;
    if (r_dir == DIR_DIAG_DL) begin
      if (int'(r_col) == LEN - 1) begin
        w_ncol = '0;
        if (int'(r_row) == LEN - 1) begin
          w_nrow = '0;
          w_wrap = 1'b1;
        end else begin
          w_nrow = r_row + 5'd1;
        end
      end else begin
        w_ncol = r_col + 5'd1;
      end
    end
  end

  // The index advances on DRAIN exit, so CMP both retires the finished window
  // and bound-checks the next one; this keeps an in-bound window at RUN+2 cycles.
  always_comb begin
    w_next = r_state;
    w_init = 1'b0;
    w_cmp  = 1'b0;
    w_adv  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_in) begin
          w_init = 1'b1;
          w_next = ST_ISSUE;
        end else begin
          w_adv  = 1'b1;
          w_next = w_wrap ? ST_FIN : ST_CHECK;
        end
      end
      ST_ISSUE: begin
        if (int'(r_k) == RUN - 1) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_adv  = 1'b1;
        w_next = ST_CMP;
      end
      ST_CMP: begin
        w_cmp = 1'b1;
        if (r_last) begin
          w_next = ST_FIN;
        end else if (w_in) begin
          w_init = 1'b1;
          w_next = ST_ISSUE;
        end else begin
          w_adv  = 1'b1;
          w_next = w_wrap ? ST_FIN : ST_CHECK;
        end
      end
      ST_FIN: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_dir   <= '0;
      r_k     <= '0;
      r_last  <= 1'b0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_vld   <= (r_state == ST_ISSUE);
      if (w_init) begin
        r_k <= '0;
      end else if (r_state == ST_ISSUE) begin
        r_k <= r_k + K_W'(1);
      end

      if (w_start_acc) begin
        r_row  <= '0;
        r_col  <= '0;
        r_dir  <= '0;
        r_last <= 1'b0;
        r_busy <= 1'b1;
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        if (w_adv) begin
          r_row <= w_nrow;
          r_col <= w_ncol;
          r_dir <= w_ndir;
          if (w_wrap) r_last <= 1'b1;
        end
        if ((w_next == ST_FIN) && (r_state != ST_FIN)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        if ((start && r_busy) || w_ovf) r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    rom_en   = 1'b0;
    rom_addr = '0;
    if (r_state == ST_ISSUE) begin
      rom_en   = 1'b1;
      rom_addr = ADDR_W'((int'(r_row) + int'(r_k) * dir_dr(r_dir)) * LEN +
                         int'(r_col) + int'(r_k) * dir_dc(r_dir));
    end
  end

  grid_win_acc #(
    .DATA_W(DATA_W),
    .RES_W (RES_W)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_start_acc),
    .i_init  (w_init),
    .i_vld   (r_vld),
    .i_data  (rom_data),
    .i_cmp   (w_cmp),
    .i_row   (r_row),
    .i_col   (r_col),
    .i_dir   (r_dir),
    .o_result(result),
    .o_row   (res_row),
    .o_col   (res_col),
    .o_dir   (res_dir),
    .o_ovf   (w_ovf)
  );

  assign busy  = r_busy;
  assign done  = r_done;
  assign error = r_err;

endmodule

// File: tb/tb_grid_scan_sched.sv
// Directed and randomized scans of grid_scan_sched against a brute-force
// window-product reference model over a behavioural ROM.
module tb_grid_scan_sched;

  localparam int N = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        rom_en;
  logic [8:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [31:0] result;
  logic [4:0]  res_row;
  logic [4:0]  res_col;
  logic [1:0]  res_dir;
  logic        busy;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_fail = 0;
  int n_bad_addr = 0;

  byte unsigned mem [N*N];
  int drs [4] = '{0, 1, 1, 1};
  int dcs [4] = '{1, 0, 1, -1};

  byte unsigned euler [N*N] = '{
    08,02,22,97,38,15,00,40,00,75,04,05,07,78,52,12,50,77,91,08,
    49,49,99,40,17,81,18,57,60,87,17,40,98,43,69,48,04,56,62,00,
    81,49,31,73,55,79,14,29,93,71,40,67,53,88,30,03,49,13,36,65,
    52,70,95,23,04,60,11,42,69,24,68,56,01,32,56,71,37,02,36,91,
    22,31,16,71,51,67,63,89,41,92,36,54,22,40,40,28,66,33,13,80,
    24,47,32,60,99,03,45,02,44,75,33,53,78,36,84,20,35,17,12,50,
    32,98,81,28,64,23,67,10,26,38,40,67,59,54,70,66,18,38,64,70,
    67,26,20,68,02,62,12,20,95,63,94,39,63,08,40,91,66,49,94,21,
    24,55,58,05,66,73,99,26,97,17,78,78,96,83,14,88,34,89,63,72,
    21,36,23,09,75,00,76,44,20,45,35,14,00,61,33,97,34,31,33,95,
    78,17,53,28,22,75,31,67,15,94,03,80,04,62,16,14,09,53,56,92,
    16,39,05,42,96,35,31,47,55,58,88,24,00,17,54,24,36,29,85,57,
    86,56,00,48,35,71,89,07,05,44,44,37,44,60,21,58,51,54,17,58,
    19,80,81,68,05,94,47,69,28,73,92,13,86,52,17,77,04,89,55,40,
    04,52,08,83,97,35,99,16,07,97,57,32,16,26,26,79,33,27,98,66,
    88,36,68,87,57,62,20,72,03,46,33,67,46,55,12,32,63,93,53,69,
    04,42,16,73,38,25,39,11,24,94,72,18,08,46,29,32,40,62,76,36,
    20,69,36,41,72,30,23,88,34,62,99,69,82,67,59,85,74,04,36,16,
    20,73,35,29,78,31,90,01,74,31,49,71,48,86,81,16,23,57,05,54,
    01,70,54,71,83,51,54,69,16,92,33,48,61,43,52,01,89,19,67,48
  };

  grid_scan_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rom_en  (rom_en),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .result  (result),
    .res_row (res_row),
    .res_col (res_col),
    .res_dir (res_dir),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en === 1'b1 && rom_addr < 9'(N*N)) rom_data <= mem[rom_addr];
  end

  always @(negedge clk) begin
    if (rom_en === 1'b1 && rom_addr >= 9'(N*N)) n_bad_addr++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: every origin in row-major order, every direction, strict max.
  task automatic model(output longint unsigned best, output int br, output int bc,
                       output int bd, output int cyc);
    best = 0; br = 0; bc = 0; bd = 0; cyc = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        for (int d = 0; d < 4; d++) begin
          int er = r + 3 * drs[d];
          int ec = c + 3 * dcs[d];
          if (er >= 0 && er < N && ec >= 0 && ec < N) begin
            longint unsigned p = 1;
            for (int k = 0; k < 4; k++)
              p = p * longint'(mem[(r + k*drs[d]) * N + c + k*dcs[d]]);
            if (p > best) begin best = p; br = r; bc = c; bd = d; end
            cyc += 6;
          end else begin
            cyc += 1;
          end
        end
  endtask

  task automatic run_scan(input int extra_at, input int rst_at,
                          output int busy_cyc, output bit timeout);
    int cyc = 0;
    busy_cyc = 0;
    timeout = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cyc < 20000) begin
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) begin timeout = 1'b0; break; end
      start = (cyc == extra_at);
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        timeout = 1'b0;
        #1;
        check("reset_abort_outputs",
              {result, res_row, res_col, res_dir, busy, done, error, rom_en, rom_addr}, '0);
        repeat (3) @(negedge clk);
        check("reset_hold_outputs",
              {result, res_row, res_col, res_dir, busy, done, error, rom_en, rom_addr}, '0);
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic scan_and_check(input string tag, input int extra_at, input bit exp_err);
    longint unsigned best;
    int br, bc, bd, mcyc, bcyc;
    bit to;
    model(best, br, bc, bd, mcyc);
    run_scan(extra_at, -1, bcyc, to);
    check({tag, "_timeout"}, 64'(to), 0);
    check({tag, "_busy_cycles"}, 64'(bcyc), 64'(mcyc));
    check({tag, "_result"}, 64'(result), best);
    check({tag, "_row"}, 64'(res_row), 64'(br));
    check({tag, "_col"}, 64'(res_col), 64'(bc));
    check({tag, "_dir"}, 64'(res_dir), 64'(bd));
    check({tag, "_done"}, 64'(done), 1);
    check({tag, "_busy_low"}, 64'(busy), 0);
    check({tag, "_error"}, 64'(error), 64'(exp_err));
  endtask

  task automatic fill_const(input byte unsigned v);
    for (int i = 0; i < N*N; i++) mem[i] = v;
  endtask

  initial begin
    int bcyc;
    bit to;
    rst_n = 1'b0;
    start = 1'b0;
    rom_data = '0;
    fill_const(8'd1);
    repeat (3) @(negedge clk);
    check("reset_state",
          {result, res_row, res_col, res_dir, busy, done, error, rom_en, rom_addr}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {busy, done, error, rom_en}, '0);

    fill_const(8'd1);
    scan_and_check("ones", -1, 1'b0);
    run_scan(-1, -1, bcyc, to);
    check("ones_busy_7890", 64'(bcyc), 7890);

    fill_const(8'd1);
    for (int c = 16; c < 20; c++) mem[19*N + c] = 8'd99;
    scan_and_check("last_row", -1, 1'b0);
    check("last_row_value", 64'(result), 96059601);

    fill_const(8'd1);
    for (int k = 0; k < 4; k++) mem[k*N + 19 - k] = 8'd50;
    scan_and_check("diag_dl", -1, 1'b0);
    check("diag_dl_value", 64'(result), 6250000);
    check("diag_dl_dir", 64'(res_dir), 3);

    for (int i = 0; i < N*N; i++) mem[i] = euler[i];
    n_bad_addr = 0;
    scan_and_check("euler", -1, 1'b0);
    check("euler_value", 64'(result), 70600674);
    check("euler_rom_addr_range", 64'(n_bad_addr), 0);

    for (int i = 0; i < N*N; i++) mem[i] = 8'($urandom_range(0, 255));
    scan_and_check("rand_full", -1, 1'b0);

    for (int i = 0; i < N*N; i++) mem[i] = 8'($urandom_range(0, 3));
    scan_and_check("rand_ties", -1, 1'b0);

    for (int i = 0; i < N*N; i++) mem[i] = euler[i];
    scan_and_check("start_while_busy", 100, 1'b1);
    check("start_while_busy_value", 64'(result), 70600674);

    run_scan(-1, 3000, bcyc, to);
    @(negedge clk);
    scan_and_check("after_reset", -1, 1'b0);
    check("after_reset_value", 64'(result), 70600674);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
